// File: rtl/flup_arbiter_pkg.sv
// flup_arbiter_pkg: FSM state type and packet-end decode shared by the FLU+ arbiter.
package flup_arbiter_pkg;
  typedef enum logic {S_IDLE, S_LOCKED} state_t;
  // shift = EOPWIDTH-SOPWIDTH converts a block pointer into a byte pointer
  function automatic logic pkt_end(input logic sop, input logic eop, input logic [31:0] sop_pos,
                                   input logic [31:0] eop_pos, input int shift);
    return eop && (!sop || (sop_pos << shift) <= eop_pos);
  endfunction
endpackage

// File: rtl/flup_rr_arbiter.sv
// flup_rr_arbiter: combinational rotating priority encoder, first request at or above ptr wins.
module flup_rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] grant,
  output logic          any
);
  always_comb begin
    grant = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) grant = PW'((int'(ptr) + k) % N);
    any = |req;
  end
endmodule

// File: rtl/flup_arbiter.sv
// flup_arbiter: packet-granular round-robin merge of RX_PORTS FLU+ streams onto one registered output.
// Define FLUP_ARB_CHANNEL_TAG_EN to drive TX_CHANNEL with the source port index instead of RX_CHANNEL.
module flup_arbiter
  import flup_arbiter_pkg::*;
#(
  parameter int RX_PORTS = 4,
  parameter int DWIDTH   = 512,
  parameter int EOPWIDTH = 6,
  parameter int SOPWIDTH = 3,
  parameter int HWIDTH   = 128,
  parameter int CHWIDTH  = 4
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic [RX_PORTS*DWIDTH-1:0]   RX_DATA,
  input  logic [RX_PORTS*HWIDTH-1:0]   RX_HEADER,
  input  logic [RX_PORTS*CHWIDTH-1:0]  RX_CHANNEL,
  input  logic [RX_PORTS*SOPWIDTH-1:0] RX_SOP_POS,
  input  logic [RX_PORTS*EOPWIDTH-1:0] RX_EOP_POS,
  input  logic [RX_PORTS-1:0]          RX_SOP,
  input  logic [RX_PORTS-1:0]          RX_EOP,
  input  logic [RX_PORTS-1:0]          RX_SRC_RDY,
  output logic [RX_PORTS-1:0]          RX_DST_RDY,
  output logic [DWIDTH-1:0]            TX_DATA,
  output logic [HWIDTH-1:0]            TX_HEADER,
  output logic [CHWIDTH-1:0]           TX_CHANNEL,
  output logic [SOPWIDTH-1:0]          TX_SOP_POS,
  output logic [EOPWIDTH-1:0]          TX_EOP_POS,
  output logic                         TX_SOP,
  output logic                         TX_EOP,
  output logic                         TX_SRC_RDY,
  input  logic                         TX_DST_RDY
);
  localparam int PW = $clog2(RX_PORTS);
  state_t state, state_nxt;
  logic [PW-1:0] grp, grp_nxt, rr_ptr, rr_nxt, arb_idx, sel, sel_inc;
  logic [CHWIDTH-1:0] ch_sel;
  logic arb_any, cand, out_free, accept, done;
  flup_rr_arbiter #(.N(RX_PORTS)) u_rr (
    .req  (RX_SRC_RDY & RX_SOP),
    .ptr  (rr_ptr),
    .grant(arb_idx),
    .any  (arb_any)
  );
  always_comb begin
    sel       = state == S_LOCKED ? grp : arb_idx;
    cand      = state == S_LOCKED || arb_any;
    out_free  = !TX_SRC_RDY || TX_DST_RDY;
    accept    = out_free && cand && RX_SRC_RDY[sel];
    done      = pkt_end(RX_SOP[sel], RX_EOP[sel], 32'(RX_SOP_POS[sel*SOPWIDTH +: SOPWIDTH]),
                        32'(RX_EOP_POS[sel*EOPWIDTH +: EOPWIDTH]), EOPWIDTH - SOPWIDTH);
    sel_inc   = sel == PW'(RX_PORTS - 1) ? '0 : sel + 1'b1;
    state_nxt = accept ? (done ? S_IDLE : S_LOCKED) : state;
    grp_nxt   = accept ? sel : grp;
    // pointer advances on every grant start and on packet end, never mid-packet
    rr_nxt    = accept && (state == S_IDLE || done) ? sel_inc : rr_ptr;
    RX_DST_RDY = RESET_N && out_free && cand ? RX_PORTS'(1) << sel : '0;
  end
`ifdef FLUP_ARB_CHANNEL_TAG_EN
  if (CHWIDTH < $clog2(RX_PORTS)) begin : g_chk
    $error("flup_arbiter: CHWIDTH too narrow to tag %0d ports", RX_PORTS);
  end
  logic unused_ch;
  assign unused_ch = ^RX_CHANNEL;
  assign ch_sel = CHWIDTH'(sel);
`else
  assign ch_sel = RX_CHANNEL[sel*CHWIDTH +: CHWIDTH];
`endif
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state      <= S_IDLE;
      grp        <= '0;
      rr_ptr     <= '0;
      TX_SRC_RDY <= 1'b0;
      TX_SOP     <= 1'b0;
      TX_EOP     <= 1'b0;
      TX_DATA    <= '0;
      TX_HEADER  <= '0;
      TX_CHANNEL <= '0;
      TX_SOP_POS <= '0;
      TX_EOP_POS <= '0;
    end else begin
      state  <= state_nxt;
      grp    <= grp_nxt;
      rr_ptr <= rr_nxt;
      if (accept) begin
        TX_SRC_RDY <= 1'b1;
        TX_SOP     <= RX_SOP[sel];
        TX_EOP     <= RX_EOP[sel];
        TX_DATA    <= RX_DATA[sel*DWIDTH +: DWIDTH];
        TX_HEADER  <= RX_HEADER[sel*HWIDTH +: HWIDTH];
        TX_CHANNEL <= ch_sel;
        TX_SOP_POS <= RX_SOP_POS[sel*SOPWIDTH +: SOPWIDTH];
        TX_EOP_POS <= RX_EOP_POS[sel*EOPWIDTH +: EOPWIDTH];
      end else if (TX_DST_RDY) begin
        TX_SRC_RDY <= 1'b0;
      end
    end
endmodule

// File: tb/tb_flup_arbiter.sv
// tb_flup_arbiter: directed FLU+ arbiter bench with a per-cycle reference model and literal log checks.
module tb_flup_arbiter;
  localparam int P = 4, DW = 32, HW = 16, CW = 4, EW = 6, SW = 3;
  typedef struct packed {
    logic [31:0] d;
    logic [15:0] h;
    logic [3:0]  c;
    logic [2:0]  sp;
    logic [5:0]  ep;
    logic        sop;
    logic        eop;
  } word_t;
  logic CLK = 0, RESET_N;
  logic [P*DW-1:0] RX_DATA;
  logic [P*HW-1:0] RX_HEADER;
  logic [P*CW-1:0] RX_CHANNEL;
  logic [P*SW-1:0] RX_SOP_POS;
  logic [P*EW-1:0] RX_EOP_POS;
  logic [P-1:0] RX_SOP, RX_EOP, RX_SRC_RDY, RX_DST_RDY;
  logic [DW-1:0] TX_DATA;
  logic [HW-1:0] TX_HEADER;
  logic [CW-1:0] TX_CHANNEL;
  logic [SW-1:0] TX_SOP_POS;
  logic [EW-1:0] TX_EOP_POS;
  logic TX_SOP, TX_EOP, TX_SRC_RDY, TX_DST_RDY;
  flup_arbiter #(.RX_PORTS(P), .DWIDTH(DW), .EOPWIDTH(EW), .SOPWIDTH(SW), .HWIDTH(HW), .CHWIDTH(CW)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .RX_DATA(RX_DATA), .RX_HEADER(RX_HEADER), .RX_CHANNEL(RX_CHANNEL),
    .RX_SOP_POS(RX_SOP_POS), .RX_EOP_POS(RX_EOP_POS), .RX_SOP(RX_SOP), .RX_EOP(RX_EOP),
    .RX_SRC_RDY(RX_SRC_RDY), .RX_DST_RDY(RX_DST_RDY), .TX_DATA(TX_DATA), .TX_HEADER(TX_HEADER),
    .TX_CHANNEL(TX_CHANNEL), .TX_SOP_POS(TX_SOP_POS), .TX_EOP_POS(TX_EOP_POS), .TX_SOP(TX_SOP),
    .TX_EOP(TX_EOP), .TX_SRC_RDY(TX_SRC_RDY), .TX_DST_RDY(TX_DST_RDY));
  always #5 CLK = ~CLK;
  int checks = 0, errors = 0, seq = 0, cyc = 0, nlog = 0;
  word_t mem [P][32];
  int head [P], tail [P];
  logic [31:0] log_d [64];
  logic [3:0]  log_c [64];
  int          log_cyc [64];
  always @(posedge CLK) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  // ---------------- source queues and driver ----------------
  task automatic push(input int p, input logic sop, input logic eop, input int sp, input int ep, input int ch);
    word_t w;
    w.d = {8'(p), 24'(seq)};
    w.h = w.d[15:0] ^ 16'hA5A5;
    w.c = 4'(ch);
    w.sp = 3'(sp);
    w.ep = 6'(ep);
    w.sop = sop;
    w.eop = eop;
    seq++;
    mem[p][tail[p]] = w;
    tail[p]++;
  endtask
  task automatic present();
    for (int i = 0; i < P; i++) begin
      word_t w;
      if (head[i] < tail[i]) begin
        w = mem[i][head[i]];
        RX_DATA[i*DW +: DW] = w.d;
        RX_HEADER[i*HW +: HW] = w.h;
        RX_CHANNEL[i*CW +: CW] = w.c;
        RX_SOP_POS[i*SW +: SW] = w.sp;
        RX_EOP_POS[i*EW +: EW] = w.ep;
        RX_SOP[i] = w.sop;
        RX_EOP[i] = w.eop;
        RX_SRC_RDY[i] = 1'b1;
      end else RX_SRC_RDY[i] = 1'b0;
    end
  endtask
  initial forever begin
    logic [P-1:0] f;
    @(negedge CLK);
    f = RX_SRC_RDY & RX_DST_RDY;
    @(posedge CLK);
    #1;
    for (int i = 0; i < P; i++) if (f[i] && head[i] < tail[i]) head[i]++;
    present();
  end
  always @(negedge CLK)
    if (RESET_N && TX_SRC_RDY && TX_DST_RDY && nlog < 64) begin
      log_d[nlog] = TX_DATA;
      log_c[nlog] = TX_CHANNEL;
      log_cyc[nlog] = cyc;
      nlog++;
    end
  // ---------------- reference model ----------------
  int own, rr;
  logic ev, e_sop, e_eop;
  logic [31:0] e_d;
  logic [15:0] e_h;
  logic [3:0]  e_c;
  logic [2:0]  e_sp;
  logic [5:0]  e_ep;
  function automatic int pick();
    if (own >= 0) return own;
    for (int k = 0; k < P; k++)
      if (RX_SRC_RDY[(rr + k) % P] && RX_SOP[(rr + k) % P]) return (rr + k) % P;
    return -1;
  endfunction
  function automatic logic ends(input int p);
    return RX_EOP[p] && (!RX_SOP[p] || int'(RX_SOP_POS[p*SW +: SW]) * 8 <= int'(RX_EOP_POS[p*EW +: EW]));
  endfunction
  always @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      own <= -1;
      rr <= 0;
      ev <= 1'b0;
    end else begin
      int p;
      p = pick();
      if ((!ev || TX_DST_RDY) && p >= 0 && RX_SRC_RDY[p]) begin
        ev <= 1'b1;
        e_d <= RX_DATA[p*DW +: DW];
        e_h <= RX_HEADER[p*HW +: HW];
`ifdef FLUP_ARB_CHANNEL_TAG_EN
        e_c <= 4'(p);
`else
        e_c <= RX_CHANNEL[p*CW +: CW];
`endif
        e_sp <= RX_SOP_POS[p*SW +: SW];
        e_ep <= RX_EOP_POS[p*EW +: EW];
        e_sop <= RX_SOP[p];
        e_eop <= RX_EOP[p];
        if (ends(p)) begin
          own <= -1;
          rr <= (p + 1) % P;
        end else begin
          own <= p;
          if (own < 0) rr <= (p + 1) % P;
        end
      end else if (TX_DST_RDY) ev <= 1'b0;
    end
  always @(negedge CLK)
    if (RESET_N) begin
      int p;
      p = pick();
      chk("tx_src_rdy", 64'(TX_SRC_RDY), 64'(ev));
      chk("rx_dst_rdy", 64'(RX_DST_RDY), ((!ev || TX_DST_RDY) && p >= 0) ? 64'(1 << p) : 64'd0);
      if (ev) begin
        chk("tx_data", 64'(TX_DATA), 64'(e_d));
        chk("tx_header", 64'(TX_HEADER), 64'(e_h));
        chk("tx_channel", 64'(TX_CHANNEL), 64'(e_c));
        chk("tx_pos", {TX_SOP_POS, TX_EOP_POS, TX_SOP, TX_EOP}, {e_sp, e_ep, e_sop, e_eop});
      end
    end
  // ---------------- directed sequences ----------------
  function automatic logic busy();
    for (int i = 0; i < P; i++) if (head[i] < tail[i]) return 1'b1;
    return TX_SRC_RDY;
  endfunction
  task automatic drain(input string nm);
    int n = 0;
    while (busy() && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) chk({nm, "_timeout"}, 64'd1, 64'd0);
    @(negedge CLK);
  endtask
  task automatic wait_src(input int p, input string nm);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!RX_SRC_RDY[p] && n < 20);
    if (!RX_SRC_RDY[p]) chk({nm, "_wait"}, 64'd1, 64'd0);
  endtask
  task automatic chk_log(input string nm, input int i, input int p, input int s);
    chk(nm, 64'(log_d[i]), 64'({8'(p), 24'(s)}));
  endtask
  initial begin
    int s, n;
    logic [3:0] pat;
    pat = 4'b1001;
    for (int i = 0; i < P; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    {RX_DATA, RX_HEADER, RX_CHANNEL, RX_SOP_POS, RX_EOP_POS, RX_SOP, RX_EOP, RX_SRC_RDY} = '0;
    TX_DST_RDY = 1'b1;
    RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_tx_src_rdy", 64'(TX_SRC_RDY), 64'd0);
    chk("rst_tx_flags", {TX_SOP, TX_EOP}, 64'd0);
    chk("rst_tx_data", 64'(TX_DATA), 64'd0);
    chk("rst_rx_dst_rdy", 64'(RX_DST_RDY), 64'd0);
    RESET_N = 1'b1;
    // 1: one single-word packet per port
    nlog = 0;
    s = seq;
    for (int p = 0; p < P; p++) push(p, 1, 1, 0, 63, p + 4);
    wait_src(0, "t1");
    chk("t1_lat0", 64'(TX_SRC_RDY), 64'd0);
    @(negedge CLK);
    chk("t1_lat1", {TX_SRC_RDY, TX_DATA}, {1'b1, 8'd0, 24'(s)});
    drain("t1");
    chk("t1_count", 64'(nlog), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk_log("t1_order", i, i, s + i);
      chk("t1_rate", 64'(log_cyc[i] - log_cyc[0]), 64'(i));
    end
    // 2: port 1 three-word packet, port 2 arrives one cycle later
    nlog = 0;
    s = seq;
    push(1, 1, 0, 0, 0, 5);
    push(1, 0, 0, 0, 0, 5);
    push(1, 0, 1, 0, 63, 5);
    wait_src(1, "t2");
    push(2, 1, 1, 0, 63, 6);
    @(negedge CLK);
    chk("t2_hold", 64'(RX_DST_RDY), 64'b0010);
    drain("t2");
    chk("t2_count", 64'(nlog), 64'd4);
    for (int i = 0; i < 4; i++) chk_log("t2_order", i, i < 3 ? 1 : 2, s + i);
    // 3: port 0 word ends a packet and starts another in the same word
    nlog = 0;
    s = seq;
    push(0, 1, 1, 4, 15, 4);
    push(0, 0, 1, 0, 63, 4);
    wait_src(0, "t3");
    push(3, 1, 1, 0, 63, 7);
    @(negedge CLK);
    chk("t3_hold", 64'(RX_DST_RDY), 64'b0001);
    drain("t3");
    chk("t3_count", 64'(nlog), 64'd3);
    for (int i = 0; i < 3; i++) chk_log("t3_order", i, i < 2 ? 0 : 3, s + i);
    // 4: output backpressure mid-packet
    nlog = 0;
    s = seq;
    push(1, 1, 0, 0, 0, 5);
    push(1, 0, 0, 0, 0, 5);
    push(1, 0, 0, 0, 0, 5);
    push(1, 0, 1, 0, 63, 5);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!TX_SRC_RDY && n < 20);
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK);
      #1 TX_DST_RDY = pat[k];
    end
    @(posedge CLK);
    #1 TX_DST_RDY = 1'b1;
    drain("t4");
    chk("t4_count", 64'(nlog), 64'd4);
    for (int i = 0; i < 4; i++) chk_log("t4_order", i, 1, s + i);
    // 5: reset in the middle of a port 2 packet
    push(2, 1, 0, 0, 0, 6);
    push(2, 0, 0, 0, 0, 6);
    push(2, 0, 1, 0, 63, 6);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(TX_SRC_RDY && TX_DATA[31:24] == 8'd2) && n < 20);
    #2 RESET_N = 1'b0;
    #1;
    chk("t5_rst_tx", 64'(TX_SRC_RDY), 64'd0);
    chk("t5_rst_rx", 64'(RX_DST_RDY), 64'd0);
    for (int i = 0; i < P; i++) head[i] = tail[i];
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("t5_rst_data", {TX_SOP, TX_EOP, TX_DATA}, 64'd0);
    RESET_N = 1'b1;
    nlog = 0;
    s = seq;
    push(3, 1, 1, 0, 63, 7);
    push(0, 1, 1, 0, 63, 4);
    drain("t5");
    chk("t5_count", 64'(nlog), 64'd2);
    chk_log("t5_first", 0, 0, s + 1);
    chk_log("t5_second", 1, 3, s);
    // 6: channel passthrough or port tag
    nlog = 0;
    push(3, 1, 1, 0, 63, 9);
    drain("t6");
    chk("t6_count", 64'(nlog), 64'd1);
`ifdef FLUP_ARB_CHANNEL_TAG_EN
    chk("t6_channel", 64'(log_c[0]), 64'd3);
`else
    chk("t6_channel", 64'(log_c[0]), 64'd9);
`endif
    // mixed traffic under random backpressure, checked by the model
    nlog = 0;
    for (int p = 0; p < P; p++) begin
      push(p, 1, 0, 0, 0, p + 4);
      push(p, 0, 1, 0, 40, p + 4);
      push(p, 1, 0, 1, 0, p + 4);
      push(p, 0, 1, 0, 63, p + 4);
    end
    n = 0;
    while (busy() && n < 300) begin
      @(posedge CLK);
      #1 TX_DST_RDY = 1'($urandom_range(0, 1));
      n++;
    end
    TX_DST_RDY = 1'b1;
    drain("mix");
    chk("mix_count", 64'(nlog), 64'd16);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
